// File: rtl/rca_config.sv
// Shared configuration for the priority-request queue block: default sizes,
// register offsets, per-channel control bundle and FSM state types.
package rca_config;

  localparam int NUM_PR_CHANNELS = 4;
  localparam int PR_QUEUE_DEPTH  = 8;

  // Read-side register offsets (addr[3:0])
  localparam logic [3:0] REG_PEEK   = 4'h0;
  localparam logic [3:0] REG_POP    = 4'h4;
  localparam logic [3:0] REG_COUNT  = 4'h8;
  localparam logic [3:0] REG_STATUS = 4'hC;

  // Write-side register offsets (addr[3:0])
  localparam logic [3:0] REG_FLUSH   = 4'h0;
  localparam logic [3:0] REG_IRQ_EN  = 4'h8;
  localparam logic [3:0] REG_OVF_CLR = 4'hC;

  typedef struct packed {
    logic push;
    logic pop;
    logic flush;
  } pr_queue_inputs_t;

  typedef enum logic [1:0] {RD_ADDR, RD_CAPTURE, RD_DATA} rdState_t;
  typedef enum logic {WR_IDLE, WR_RESP} wrState_t;

endpackage

// File: rtl/pr_channel_fifo.sv
// Single-channel request FIFO; flush overrides push and pop in the same cycle,
// pushes into a full queue and pops from an empty queue are ignored.
module pr_channel_fifo
  import rca_config::*;
#(
  parameter int DEPTH  = PR_QUEUE_DEPTH,
  parameter int DATA_W = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_count;
  logic              w_doPush;
  logic              w_doPop;

  assign full     = (r_count == CNT_W'(DEPTH));
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign data_out = r_mem[r_rdPtr];
  assign w_doPush = push && !full;
  assign w_doPop  = pop && !empty;

  // DEPTH is a power of two, so pointer increments wrap naturally
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      r_count <= r_count + CNT_W'(w_doPush) - CNT_W'(w_doPop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush && !flush && !rst) r_mem[r_wrPtr] <= push_data;
  end

endmodule

// File: rtl/axi_pr_multi_queue.sv
// Multi-channel priority-request queue with an AXI-lite register window:
// addr[7:4] selects the channel, addr[3:0] the register.
module axi_pr_multi_queue
  import rca_config::*;
#(
  parameter int NUM_CHANNELS = NUM_PR_CHANNELS,
  parameter int QUEUE_DEPTH  = PR_QUEUE_DEPTH,
  parameter int DATA_W       = 16,
  localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_valid,
  input  logic [CH_W-1:0]   push_channel,
  input  logic [DATA_W-1:0] push_data,
  output logic              push_ready,
  input  logic [7:0]        s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [7:0]        s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic              pr_request_pending
);

  rdState_t          r_rdState;
  wrState_t          r_wrState;
  logic [7:0]        r_araddr;
  logic              r_arready;
  logic              r_rvalid;
  logic [31:0]       r_rdata;
  logic              r_awready;
  logic              r_bvalid;
  logic [NUM_CHANNELS-1:0] r_irqEn;
  logic [NUM_CHANNELS-1:0] r_overflow;

  pr_queue_inputs_t  w_ctrl [NUM_CHANNELS];
  logic [DATA_W-1:0] w_head [NUM_CHANNELS];
  logic [CNT_W-1:0]  w_count [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] w_full;
  logic [NUM_CHANNELS-1:0] w_empty;
  logic [NUM_CHANNELS-1:0] w_flush;

  logic [CH_W-1:0]   w_rdIdx;
  logic              w_rdChOk;
  logic [3:0]        w_rdReg;
  logic [CH_W-1:0]   w_wrIdx;
  logic              w_wrChOk;
  logic [3:0]        w_wrReg;
  logic              w_wrFire;
  logic [31:0]       w_rdValue;
  logic [31:0]       w_head32;
  logic              w_unused;

  assign w_rdIdx  = r_araddr[4 +: CH_W];
  assign w_rdChOk = ({1'b0, r_araddr[7:4]} < 5'(NUM_CHANNELS));
  assign w_rdReg  = r_araddr[3:0];
  assign w_wrIdx  = s_axi_awaddr[4 +: CH_W];
  assign w_wrChOk = ({1'b0, s_axi_awaddr[7:4]} < 5'(NUM_CHANNELS));
  assign w_wrReg  = s_axi_awaddr[3:0];
  assign w_wrFire = (r_wrState == WR_IDLE) && r_awready;
  assign w_unused = &{1'b0, s_axi_wdata[31:3], s_axi_wdata[1]};

  assign push_ready         = !w_full[push_channel] && !w_flush[push_channel];
  assign pr_request_pending = |(~w_empty & r_irqEn);
  assign s_axi_arready      = r_arready;
  assign s_axi_rvalid       = r_rvalid;
  assign s_axi_rdata        = r_rdata;
  assign s_axi_awready      = r_awready;
  assign s_axi_wready       = r_awready;
  assign s_axi_bvalid       = r_bvalid;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    assign w_flush[g]      = w_wrFire && w_wrChOk && (w_wrReg == REG_FLUSH) && (w_wrIdx == CH_W'(g));
    assign w_ctrl[g].flush = w_flush[g];
    assign w_ctrl[g].push  = push_valid && push_ready && (push_channel == CH_W'(g));
    assign w_ctrl[g].pop   = (r_rdState == RD_CAPTURE) && w_rdChOk && (w_rdReg == REG_POP) &&
                             (w_rdIdx == CH_W'(g));

    pr_channel_fifo #(.DEPTH(QUEUE_DEPTH), .DATA_W(DATA_W)) u_fifo (
      .clk(clk), .rst(rst),
      .push(w_ctrl[g].push), .pop(w_ctrl[g].pop), .flush(w_ctrl[g].flush),
      .push_data(push_data), .data_out(w_head[g]), .count(w_count[g]),
      .full(w_full[g]), .empty(w_empty[g])
    );
  end

  // Empty heads read as zero so PEEK/POP of an empty channel return 0
  always_comb begin
    w_rdValue = '0;
    w_head32  = '0;
    if (w_rdChOk) begin
      if (!w_empty[w_rdIdx]) w_head32[DATA_W-1:0] = w_head[w_rdIdx];
      case (w_rdReg)
        REG_PEEK, REG_POP: w_rdValue = w_head32;
        REG_COUNT:         w_rdValue[CNT_W-1:0] = w_count[w_rdIdx];
        REG_STATUS:        w_rdValue[3:0] = {r_irqEn[w_rdIdx], r_overflow[w_rdIdx],
                                             w_full[w_rdIdx], !w_empty[w_rdIdx]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdState <= RD_ADDR;
      r_araddr  <= '0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      case (r_rdState)
        RD_ADDR: if (s_axi_arvalid) begin
          r_araddr  <= s_axi_araddr;
          r_arready <= 1'b1;
          r_rdState <= RD_CAPTURE;
        end
        RD_CAPTURE: begin
          r_arready <= 1'b0;
          r_rdata   <= w_rdValue;
          r_rvalid  <= 1'b1;
          r_rdState <= RD_DATA;
        end
        RD_DATA: if (s_axi_rready) begin
          r_rvalid  <= 1'b0;
          r_rdState <= RD_ADDR;
        end
        default: r_rdState <= RD_ADDR;
      endcase
    end
  end

  // Ready pulse cycle is the cycle the register effect is applied
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrState <= WR_IDLE;
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
    end else begin
      case (r_wrState)
        WR_IDLE: begin
          if (r_awready) begin
            r_awready <= 1'b0;
            r_bvalid  <= 1'b1;
            r_wrState <= WR_RESP;
          end else if (s_axi_awvalid && s_axi_wvalid) begin
            r_awready <= 1'b1;
          end
        end
        WR_RESP: if (s_axi_bready) begin
          r_bvalid  <= 1'b0;
          r_wrState <= WR_IDLE;
        end
        default: r_wrState <= WR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_irqEn    <= '0;
      r_overflow <= '0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (w_wrFire && w_wrChOk && (w_wrIdx == CH_W'(i))) begin
          if (w_wrReg == REG_IRQ_EN) r_irqEn[i] <= s_axi_wdata[0];
          if ((w_wrReg == REG_OVF_CLR) && s_axi_wdata[2]) r_overflow[i] <= 1'b0;
        end
        if (push_valid && !push_ready && (push_channel == CH_W'(i))) r_overflow[i] <= 1'b1;
      end
    end
  end

endmodule

// File: doc/axi_pr_multi_queue.md
AXI_PR_MULTI_QUEUE -- requirements
Module: axi_pr_multi_queue

Interface
REQ-001 Parameter NUM_CHANNELS, default 4: number of independent request queues (1..16).
REQ-002 Parameter QUEUE_DEPTH, default 8: entries per channel, power of two, ≥2.
REQ-003 Parameter DATA_W, default 16: request payload width (≤32).
REQ-004 Ports: clk in 1, the single clock; rst in 1, synchronous active-high reset.
REQ-005 Push ports: push_valid in 1, push_channel in $clog2(NUM_CHANNELS), push_data in DATA_W, push_ready out 1.
REQ-006 AXI-lite write ports: s_axi_awaddr in 8, s_axi_awvalid in 1, s_axi_awready out 1, s_axi_wdata in 32, s_axi_wvalid in 1, s_axi_wready out 1, s_axi_bvalid out 1, s_axi_bready in 1.
REQ-007 AXI-lite read ports: s_axi_araddr in 8, s_axi_arvalid in 1, s_axi_arready out 1, s_axi_rdata out 32, s_axi_rvalid out 1, s_axi_rready in 1.
REQ-008 pr_request_pending out 1: OR over channels of (non-empty AND irq_en[ch]).

Function
REQ-009 Address decode: addr[7:4] = channel, addr[3:0] = register; channel ≥ NUM_CHANNELS reads 0 and ignores writes.
REQ-010 Read registers: 0x0 PEEK (head data, zero-extended), 0x4 POP (head data, then remove head), 0x8 COUNT (occupancy), 0xC STATUS (bit0 non-empty, bit1 full, bit2 overflow, bit3 irq_en).
REQ-011 Write registers: 0x0 FLUSH (any data empties channel), 0x8 IRQ_EN (wdata[0]), 0xC wdata[2]=1 clears overflow sticky.
REQ-012 push_ready = !full[push_channel] AND no flush of push_channel this cycle; push accepted when push_valid && push_ready.
REQ-013 push_valid with push_ready low sets overflow[push_channel]; data discarded.
REQ-014 Read FSM states ADDR→CAPTURE→DATA→ADDR; arready one-cycle pulse on ADDR exit; rvalid asserted from CAPTURE exit and held until rready; arvalid-to-rvalid latency 2 cycles.
REQ-015 POP removes the head in the same cycle rdata is captured; POP on empty channel returns 0 and leaves state unchanged.
REQ-016 Write FSM states WIDLE→WRESP→WIDLE; awready and wready pulse together for one cycle only when both awvalid and wvalid high; register effect takes place on that cycle; bvalid held until bready.
REQ-017 Simultaneous push and POP on same channel: both take effect; COUNT unchanged; allowed when not full, and when full only the pop occurs.
REQ-018 Simultaneous FLUSH and POP on same channel: flush wins; POP returns captured head data but count goes to 0.
REQ-019 Pointers wrap modulo QUEUE_DEPTH; COUNT width $clog2(QUEUE_DEPTH+1), ranges 0..QUEUE_DEPTH.
REQ-020 FIFO order preserved per channel; channels fully independent.

Reset
REQ-021 On rst: all queues empty, overflow=0, irq_en=0, both FSMs in idle state, all AXI ready/valid outputs 0, rdata 0, pr_request_pending 0.
REQ-022 rst mid-transaction abandons the transaction without a response; rst has priority over every other event.

Structure
REQ-023 NUM_PR_CHANNELS, PR_QUEUE_DEPTH, register offset constants and pr_queue_inputs_t belong in rca_config.
REQ-024 One sub-module pr_channel_fifo (push, pop, flush, data_out, count, full, empty), instantiated NUM_CHANNELS times via generate.

Verification
REQ-025 Push 0x11,0x22 on ch1; read 0x14 twice → rdata 0x11 then 0x22; COUNT 0x18 reads 0.
REQ-026 Push 9 entries on ch0 with depth 8 → push_ready low on 9th; STATUS bits = full|overflow (0x7); write 0xC with 0x4 → STATUS 0x3.
REQ-027 Write IRQ_EN ch2=1, push on ch2 → pr_request_pending 1 next cycle; POP ch2 → pending 0.
REQ-028 POP on empty ch3 (0x34) → rdata 0, COUNT remains 0, no underflow wrap.
REQ-029 ch0 holds 3 entries; FLUSH ch0 with concurrent push to ch0 → push_ready 0 that cycle, COUNT 0 afterwards.
REQ-030 Hold rready low 5 cycles after PEEK → rvalid stays high, rdata stable, no second pop.
